// File: rtl/const_load_sequencer.sv
// Sequences loadlit/lcl/lch around the constant extender and register file.
// loadlit writes the extended constant; lcl/lch read-modify-write one byte.
module const_load_sequencer #(
   parameter int DATA_W    = 16,
   parameter int CONST_W   = 11,
   parameter int RF_ADDR_W = 3
) (
   input  logic                 clock,
   input  logic                 reset,
   input  logic                 req_valid,
   output logic                 req_ready,
   input  logic [1:0]           req_op,
   input  logic [RF_ADDR_W-1:0] req_dest,
   input  logic [CONST_W-1:0]   req_const,
   output logic [1:0]           ext_controle,
   output logic [CONST_W-1:0]   ext_constante,
   input  logic [DATA_W-1:0]    ext_extendida,
   output logic                 rf_rd_en,
   output logic [RF_ADDR_W-1:0] rf_rd_addr,
   input  logic [DATA_W-1:0]    rf_rd_data,
   output logic                 rf_wr_en,
   output logic [RF_ADDR_W-1:0] rf_wr_addr,
   output logic [DATA_W-1:0]    rf_wr_data,
   output logic                 done,
   output logic                 err,
   output logic [7:0]           op_count
);

   localparam logic [2:0] IDLE  = 3'd0;
   localparam logic [2:0] LOAD  = 3'd1;
   localparam logic [2:0] READ  = 3'd2;
   localparam logic [2:0] MERGE = 3'd3;
   localparam logic [2:0] WRITE = 3'd4;
   localparam logic [2:0] ERR   = 3'd5;

   localparam logic [1:0] OP_LOADLIT = 2'b00;
   localparam logic [1:0] OP_LCL     = 2'b01;
   localparam logic [1:0] OP_LCH     = 2'b10;

   logic [2:0]           state;
   logic [2:0]           state_nxt;
   logic [1:0]           op_q;
   logic [RF_ADDR_W-1:0] dest_q;
   logic [CONST_W-1:0]   const_q;
   logic [DATA_W-1:0]    result_q;

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            if (req_valid) begin
               case (req_op)
                  OP_LOADLIT:     state_nxt = LOAD;
                  OP_LCL, OP_LCH: state_nxt = READ;
                  default:        state_nxt = ERR;
               endcase
            end
         end
         LOAD:    state_nxt = WRITE;
         READ:    state_nxt = MERGE;
         MERGE:   state_nxt = WRITE;
         WRITE:   state_nxt = IDLE;
         ERR:     state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state    <= IDLE;
         op_q     <= '0;
         dest_q   <= '0;
         const_q  <= '0;
         result_q <= '0;
         op_count <= '0;
      end else begin
         state <= state_nxt;
         case (state)
            IDLE: begin
               if (req_valid) begin
                  op_q    <= req_op;
                  dest_q  <= req_dest;
                  const_q <= req_const;
               end
            end
            LOAD: result_q <= ext_extendida;
            MERGE: begin
               // Byte placement of the constant is done by the extender; only the kept byte comes from the register.
               if (op_q == OP_LCL)
                  result_q <= {rf_rd_data[DATA_W-1:8], ext_extendida[7:0]};
               else
                  result_q <= {ext_extendida[DATA_W-1:8], rf_rd_data[7:0]};
            end
            WRITE:   op_count <= op_count + 8'd1;
            default: ;
         endcase
      end
   end

   // The illegal op code is masked so the extender never sees its undefined control value.
   assign ext_controle  = (op_q == 2'b11) ? 2'b00 : op_q;
   assign ext_constante = const_q;

   assign req_ready  = (state == IDLE);
   assign rf_rd_en   = (state == READ);
   assign rf_rd_addr = dest_q;
   assign rf_wr_en   = (state == WRITE);
   assign rf_wr_addr = dest_q;
   assign rf_wr_data = result_q;
   assign done       = (state == WRITE);
   assign err        = (state == ERR);

endmodule

// File: tb/tb_const_load_sequencer.sv
// Randomized bench for const_load_sequencer with an extender model, a register
// file model and a byte-level reference of the expected register contents.
module tb_const_load_sequencer;

   localparam int DATA_W    = 16;
   localparam int CONST_W   = 11;
   localparam int RF_ADDR_W = 3;

   logic                 clock;
   logic                 reset;
   logic                 req_valid;
   logic                 req_ready;
   logic [1:0]           req_op;
   logic [RF_ADDR_W-1:0] req_dest;
   logic [CONST_W-1:0]   req_const;
   logic [1:0]           ext_controle;
   logic [CONST_W-1:0]   ext_constante;
   logic [DATA_W-1:0]    ext_extendida;
   logic                 rf_rd_en;
   logic [RF_ADDR_W-1:0] rf_rd_addr;
   logic [DATA_W-1:0]    rf_rd_data;
   logic                 rf_wr_en;
   logic [RF_ADDR_W-1:0] rf_wr_addr;
   logic [DATA_W-1:0]    rf_wr_data;
   logic                 done;
   logic                 err;
   logic [7:0]           op_count;

   const_load_sequencer #(
      .DATA_W   (DATA_W),
      .CONST_W  (CONST_W),
      .RF_ADDR_W(RF_ADDR_W)
   ) dut (
      .clock        (clock),
      .reset        (reset),
      .req_valid    (req_valid),
      .req_ready    (req_ready),
      .req_op       (req_op),
      .req_dest     (req_dest),
      .req_const    (req_const),
      .ext_controle (ext_controle),
      .ext_constante(ext_constante),
      .ext_extendida(ext_extendida),
      .rf_rd_en     (rf_rd_en),
      .rf_rd_addr   (rf_rd_addr),
      .rf_rd_data   (rf_rd_data),
      .rf_wr_en     (rf_wr_en),
      .rf_wr_addr   (rf_wr_addr),
      .rf_wr_data   (rf_wr_data),
      .done         (done),
      .err          (err),
      .op_count     (op_count)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Extender: 00 sign-extend, 01 low byte, 10 low byte placed in the high byte.
   always_comb begin
      case (ext_controle)
         2'b00:   ext_extendida = {{5{ext_constante[10]}}, ext_constante};
         2'b01:   ext_extendida = {8'h00, ext_constante[7:0]};
         2'b10:   ext_extendida = {ext_constante[7:0], 8'h00};
         default: ext_extendida = 16'hDEAD;
      endcase
   end

   // Register file environment with a preload port used only while idle.
   logic [DATA_W-1:0]    mem [8];
   logic                 pl_en;
   logic [RF_ADDR_W-1:0] pl_addr;
   logic [DATA_W-1:0]    pl_data;

   always @(posedge clock) begin
      if (pl_en) mem[pl_addr] <= pl_data;
      else if (rf_wr_en) mem[rf_wr_addr] <= rf_wr_data;
      if (rf_rd_en) rf_rd_data <= mem[rf_rd_addr];
   end

   logic [DATA_W-1:0] model_rf [8];
   logic [7:0]        cnt_m;
   int                n_cmp;
   int                n_bad;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic check_reset_vals();
      check("rst_rd_en", rf_rd_en, 0);
      check("rst_wr_en", rf_wr_en, 0);
      check("rst_done", done, 0);
      check("rst_err", err, 0);
      check("rst_ctl", ext_controle, 0);
      check("rst_const", ext_constante, 0);
      check("rst_rd_addr", rf_rd_addr, 0);
      check("rst_wr_addr", rf_wr_addr, 0);
      check("rst_wr_data", rf_wr_data, 0);
      check("rst_count", op_count, 0);
   endtask

   task automatic pulse_reset();
      @(negedge clock);
      reset = 1'b0;
      #1 check_reset_vals();
      @(negedge clock);
      @(negedge clock);
      reset = 1'b1;
      cnt_m = 8'd0;
   endtask

   // Called at a falling edge with the DUT idle; returns at the falling edge of the next idle cycle.
   task automatic do_req(input logic [1:0] op, input logic [2:0] dest, input logic [10:0] c);
      logic [15:0] exp_w;
      logic [1:0]  exp_ctl;
      check("ready_idle", req_ready, 1);
      check("count", op_count, cnt_m);
      req_valid = 1'b1;
      req_op    = op;
      req_dest  = dest;
      req_const = c;
      exp_ctl   = (op == 2'b11) ? 2'b00 : op;
      case (op)
         2'b00:   exp_w = {{5{c[10]}}, c};
         2'b01:   exp_w = {model_rf[dest][15:8], c[7:0]};
         2'b10:   exp_w = {c[7:0], model_rf[dest][7:0]};
         default: exp_w = 16'h0;
      endcase
      @(posedge clock);
      @(negedge clock);
      // Busy: keep presenting junk requests that must be ignored.
      req_op    = 2'($urandom);
      req_dest  = 3'($urandom);
      req_const = 11'($urandom);
      check("ready_busy", req_ready, 0);
      check("ext_ctl_t1", ext_controle, exp_ctl);
      check("ext_const_t1", ext_constante, c);
      check("wr_en_t1", rf_wr_en, 0);
      if (op == 2'b11) begin
         check("err_t1", err, 1);
         check("rd_en_err", rf_rd_en, 0);
         check("done_err", done, 0);
         req_valid = 1'b0;
         @(negedge clock);
         check("err_clear", err, 0);
      end else begin
         check("err_t1", err, 0);
         if (op != 2'b00) begin
            check("rd_en_t1", rf_rd_en, 1);
            check("rd_addr_t1", rf_rd_addr, dest);
            @(negedge clock);
            check("rd_en_t2", rf_rd_en, 0);
            check("wr_en_t2", rf_wr_en, 0);
            check("ready_t2", req_ready, 0);
            check("ext_ctl_t2", ext_controle, exp_ctl);
         end else begin
            check("rd_en_t1", rf_rd_en, 0);
         end
         @(negedge clock);
         check("wr_en", rf_wr_en, 1);
         check("wr_addr", rf_wr_addr, dest);
         check("wr_data", rf_wr_data, exp_w);
         check("done", done, 1);
         check("ready_wr", req_ready, 0);
         check("ext_ctl_wr", ext_controle, exp_ctl);
         req_valid     = 1'b0;
         model_rf[dest] = exp_w;
         cnt_m++;
         @(negedge clock);
         check("wr_clear", rf_wr_en, 0);
         check("done_clear", done, 0);
         check("rf_commit", mem[dest], model_rf[dest]);
      end
   endtask

   initial begin
      n_cmp     = 0;
      n_bad     = 0;
      cnt_m     = 8'd0;
      reset     = 1'b0;
      req_valid = 1'b0;
      req_op    = 2'b00;
      req_dest  = '0;
      req_const = '0;
      pl_en     = 1'b0;
      pl_addr   = '0;
      pl_data   = '0;
      #1 check_reset_vals();
      for (int i = 0; i < 8; i++) begin
         @(negedge clock);
         pl_en   = 1'b1;
         pl_addr = 3'(i);
         pl_data = (i == 1) ? 16'hBEEF : (i == 2) ? 16'h1234 : 16'($urandom);
         model_rf[i] = pl_data;
      end
      @(negedge clock);
      pl_en = 1'b0;
      check_reset_vals();
      reset = 1'b1;

      do_req(2'b00, 3'd3, 11'h400);
      check("ll_neg", model_rf[3], 16'hFC00);
      do_req(2'b00, 3'd5, 11'h3FF);
      check("ll_pos", model_rf[5], 16'h03FF);
      do_req(2'b01, 3'd2, 11'h7A5);
      check("lcl_r2", model_rf[2], 16'h12A5);
      do_req(2'b10, 3'd1, 11'h05A);
      check("lch_r1", model_rf[1], 16'h5AEF);
      do_req(2'b11, 3'd4, 11'h123);

      // Reset during an lch MERGE cycle.
      req_valid = 1'b1; req_op = 2'b10; req_dest = 3'd6; req_const = 11'h0C3;
      @(posedge clock);
      @(negedge clock);
      req_valid = 1'b0;
      @(negedge clock);
      reset = 1'b0;
      #1 check_reset_vals();
      @(negedge clock);
      check("rst_merge_wr", rf_wr_en, 0);
      reset = 1'b1;
      cnt_m = 8'd0;
      check("rst_merge_mem", mem[6], model_rf[6]);
      do_req(2'b00, 3'd0, 11'h001);

      // Reset landing in the WRITE cycle must withdraw the strobe before the edge.
      req_valid = 1'b1; req_op = 2'b00; req_dest = 3'd7; req_const = 11'h2AA;
      @(posedge clock);
      @(negedge clock);
      req_valid = 1'b0;
      @(negedge clock);
      check("wr_before_rst", rf_wr_en, 1);
      reset = 1'b0;
      #1 check("wr_async_drop", rf_wr_en, 0);
      check("done_async_drop", done, 0);
      @(negedge clock);
      check("rst_wr_mem", mem[7], model_rf[7]);
      reset = 1'b1;
      cnt_m = 8'd0;

      for (int i = 0; i < 150; i++)
         do_req(2'($urandom), 3'($urandom), 11'($urandom));

      pulse_reset();
      for (int i = 0; i < 256; i++)
         do_req(2'b00, 3'($urandom), 11'($urandom));
      check("count_wrap", op_count, 8'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
